snake_mover: RTL

Per-player snake body generator: on each game tick it advances the snake one cell in the commanded direction, wraps at the playfield edges, lengthens on food, and drives the packed body vector that `collision_check` consumes. One instance per player. Each instance's `should_stop` from `collision_check` feeds back to freeze that snake. All state is in this block; the collision checker is purely a reader of its output.

---
 rtl/snake_mover_if.sv | 27 ++
 rtl/snake_mover.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/snake_mover_if.sv
// Handshake/bus bundle between a game controller and one snake_mover.
// master drives the control pulses, slave produces the body outputs.
interface snake_mover_if #(
    parameter int MAX_LEN = 16
);
    logic                    tick;
    logic [1:0]              dir_in;
    logic                    dir_valid;
    logic                    grow;
    logic                    stop_in;
    logic                    restart;
    logic [MAX_LEN*10-1:0]   snake;
    logic [9:0]              head;
    logic [4:0]              length;
    logic                    moved;
    logic                    halted;

    modport master (
        output tick, dir_in, dir_valid, grow, stop_in, restart,
        input  snake, head, length, moved, halted
    );

    modport slave (
        input  tick, dir_in, dir_valid, grow, stop_in, restart,
        output snake, head, length, moved, halted
    );
endinterface

// File: rtl/snake_mover.sv
// Per-player snake body generator: moves, wraps, grows and freezes
// one snake, publishing its packed body for the collision checker.
module snake_mover #(
    parameter int         MAX_LEN   = 16,
    parameter int         GRID_MAX  = 30,
    parameter logic [9:0] INIT_HEAD = 10'h002,
    parameter logic [9:0] INIT_TAIL = 10'h001
) (
    input logic         clk,
    input logic         rst_n,
    snake_mover_if.slave bus
);
    localparam logic [9:0] EMPTY = 10'h3FF;
    localparam logic [4:0] GMAX  = 5'(GRID_MAX);
    localparam logic [4:0] LMAX  = 5'(MAX_LEN);

    localparam logic [1:0] D_UP    = 2'b00;
    localparam logic [1:0] D_DOWN  = 2'b01;
    localparam logic [1:0] D_LEFT  = 2'b10;
    localparam logic [1:0] D_RIGHT = 2'b11;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [MAX_LEN-1:0][9:0]   r_body;
    logic [4:0]                r_len;
    logic [1:0]                r_cur_dir;
    logic [1:0]                r_last_dir;
    logic [2:0]                r_pend;
    logic                      r_moved;

    logic                      w_run;
    logic                      w_move;
    logic                      w_dir_ok;
    logic [1:0]                w_dir;
    logic [2:0]                w_pend_inc;
    logic                      w_full;
    logic                      w_grow_now;
    logic [4:0]                w_len_n;
    logic [4:0]                w_row;
    logic [4:0]                w_col;
    logic [4:0]                w_row_n;
    logic [4:0]                w_col_n;
    logic [MAX_LEN-1:0][9:0]   w_body_n;
    logic [MAX_LEN-1:0][9:0]   w_body_init;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: restart dominates, stop freezes a running snake
    always_comb begin
        w_state_nxt = r_state;
        if (bus.restart) begin
            w_state_nxt = RUN;
        end else if (r_state == RUN && bus.stop_in) begin
            w_state_nxt = HALT;
        end
    end

    // FSM outputs: move/turn/grow qualifiers for the datapath
    always_comb begin
        w_run      = (r_state == RUN) && !bus.restart;
        w_move     = w_run && !bus.stop_in && bus.tick;
        // reverse of a direction only differs in bit 0
        w_dir_ok   = w_run && bus.dir_valid &&
                     (bus.dir_in != (r_last_dir ^ 2'b01));
        w_dir      = w_dir_ok ? bus.dir_in : r_cur_dir;
        w_pend_inc = r_pend;
        if (w_run && bus.grow && r_pend != 3'd7) begin
            w_pend_inc = r_pend + 3'd1;
        end
        w_full     = (r_len == LMAX);
        w_grow_now = w_move && !w_full && (w_pend_inc != 3'd0);
        w_len_n    = w_grow_now ? r_len + 5'd1 : r_len;
    end

    always_comb begin
        w_row   = r_body[0][9:5];
        w_col   = r_body[0][4:0];
        w_row_n = w_row;
        w_col_n = w_col;
        unique case (w_dir)
            D_UP:    w_row_n = (w_row == 5'd0) ? GMAX : w_row - 5'd1;
            D_DOWN:  w_row_n = (w_row >= GMAX) ? 5'd0 : w_row + 5'd1;
            D_LEFT:  w_col_n = (w_col == 5'd0) ? GMAX : w_col - 5'd1;
            D_RIGHT: w_col_n = (w_col >= GMAX) ? 5'd0 : w_col + 5'd1;
            default: ;
        endcase
    end

    // Shift body one slot; the extra slot on growth keeps the old tail
    always_comb begin
        w_body_n    = r_body;
        w_body_init = r_body;
        w_body_n[0] = {w_row_n, w_col_n};
        for (int i = 1; i < MAX_LEN; i++) begin
            w_body_n[i] = (5'(i) < w_len_n) ? r_body[i-1] : EMPTY;
        end
        for (int i = 0; i < MAX_LEN; i++) begin
            w_body_init[i] = EMPTY;
        end
        w_body_init[0] = INIT_HEAD;
        w_body_init[1] = INIT_TAIL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_body[i] <= EMPTY;
            end
            r_body[0]  <= INIT_HEAD;
            r_body[1]  <= INIT_TAIL;
            r_len      <= 5'd2;
            r_cur_dir  <= D_RIGHT;
            r_last_dir <= D_RIGHT;
            r_pend     <= 3'd0;
            r_moved    <= 1'b0;
        end else if (bus.restart) begin
            r_body     <= w_body_init;
            r_len      <= 5'd2;
            r_cur_dir  <= D_RIGHT;
            r_last_dir <= D_RIGHT;
            r_pend     <= 3'd0;
            r_moved    <= 1'b0;
        end else if (w_run) begin
            r_moved <= w_move;
            if (w_move) begin
                r_body     <= w_body_n;
                r_len      <= w_len_n;
                r_cur_dir  <= w_dir;
                r_last_dir <= w_dir;
                if (w_full) begin
                    r_pend <= 3'd0;
                end else if (w_grow_now) begin
                    r_pend <= w_pend_inc - 3'd1;
                end else begin
                    r_pend <= w_pend_inc;
                end
            end else begin
                r_cur_dir <= w_dir;
                r_pend    <= w_pend_inc;
            end
        end else begin
            r_moved <= 1'b0;
        end
    end

    assign bus.snake  = r_body;
    assign bus.head   = r_body[0];
    assign bus.length = r_len;
    assign bus.moved  = r_moved;
    assign bus.halted = (r_state == HALT);
endmodule
